// File: rtl/fb_pkg.sv
// Shared framebuffer constants, SPI opcodes and the parser state encoding.
// The VGA read-address generator imports the same geometry constants.
package fb_pkg;

    // 640x480 at 1 bpp
    localparam int unsigned FB_BYTES_DEFAULT = 38400;
    localparam int unsigned ADDR_W_DEFAULT   = 16;

    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_FILL   = 8'h02;
    localparam logic [7:0] OP_STATUS = 8'h03;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_FILL_VAL,
        ST_FILL,
        ST_DISCARD
    } state_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for a single asynchronous level signal.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic main_clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw level through two flops; both start at the idle level.
    // NOTE: clocked state uses <= so every flop samples its pre-edge input;
    // with = the second flop would see the first one's new value in the same edge.
    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_fb_writer.sv
// SPI command parser driving the screen RAM write port: framed WRITE with
// auto-incrementing wrapped pointer, hardware FILL, sticky error and a
// status byte for the SPI transmit path.
module spi_fb_writer
    import fb_pkg::*;
#(
    parameter int unsigned FB_BYTES = FB_BYTES_DEFAULT,
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT
) (
    input  logic              main_clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              rx_dv,
    input  logic [7:0]        rx_byte,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_en,
    output logic [7:0]        tx_byte,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);

    state_t            state, state_d;
    logic              cs_s;
    logic [ADDR_W-1:0] ptr, ptr_d;
    logic [7:0]        addr_hi, addr_hi_d;
    logic [7:0]        fill_val, fill_val_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [7:0]        wr_data_d;
    logic              err_set, err_clr, err_d;
    logic [15:0]       hdr_addr;
    logic              hdr_ok;

    // Wrap is an explicit compare against the last framebuffer byte, so a
    // framebuffer smaller than 2**ADDR_W never walks into unmapped addresses.
    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    // Chip select idles high, so the synchronizer resets to deasserted.
    sync2 #(.RESET_VAL(1'b1)) u_cs_sync (
        .main_clk (main_clk),
        .rst      (rst),
        .d        (cs_n),
        .q        (cs_s)
    );

    assign hdr_addr = {addr_hi, rx_byte};
    assign hdr_ok   = 32'(hdr_addr) < FB_BYTES;
    assign busy     = (state == ST_FILL);

    // Parser state register.
    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) state <= ST_CMD;
        else     state <= state_d;
    end

    // Next-state, pointer and registered write-port decode.
    // NOTE: every signal gets its hold/idle value before the case so no path
    // leaves one unassigned, which is what would otherwise infer a latch.
    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        addr_hi_d  = addr_hi;
        fill_val_d = fill_val;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        err_set    = 1'b0;
        err_clr    = 1'b0;

        case (state)
            ST_CMD: begin
                if (rx_dv) begin
                    case (rx_byte)
                        OP_WRITE:  state_d = ST_ADDR_HI;
                        OP_FILL:   state_d = ST_FILL_VAL;
                        OP_STATUS: begin
                            err_clr = 1'b1;
                            state_d = ST_DISCARD;
                        end
                        default: begin
                            err_set = 1'b1;
                            state_d = ST_DISCARD;
                        end
                    endcase
                end
            end
            ST_ADDR_HI: begin
                if (rx_dv) begin
                    addr_hi_d = rx_byte;
                    state_d   = ST_ADDR_LO;
                end
            end
            ST_ADDR_LO: begin
                if (rx_dv) begin
                    if (hdr_ok) begin
                        ptr_d   = ADDR_W'(hdr_addr);
                        state_d = ST_DATA;
                    end else begin
                        err_set = 1'b1;
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_DATA: begin
                if (rx_dv) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr;
                    wr_data_d = rx_byte;
                    ptr_d     = next_ptr(ptr);
                end
            end
            ST_FILL_VAL: begin
                // The write to address 0 is issued here so the first fill
                // write lands one cycle after the value byte; the pointer
                // then holds the address of the following write.
                if (rx_dv) begin
                    fill_val_d = rx_byte;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = '0;
                    wr_data_d  = rx_byte;
                    ptr_d      = next_ptr('0);
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (rx_dv) err_set = 1'b1;
                if (wr_addr == LAST_ADDR) begin
                    state_d = cs_s ? ST_CMD : ST_DISCARD;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr;
                    wr_data_d = fill_val;
                    ptr_d     = next_ptr(ptr);
                end
            end
            ST_DISCARD: ;
            default:    state_d = ST_CMD;
        endcase

        // End of transaction returns to CMD, but a fill whose first write is
        // already out always runs to completion.
        if (cs_s && state != ST_FILL && state_d != ST_FILL) state_d = ST_CMD;

        err_d = (err | err_set) & ~err_clr;
    end

    // Datapath and output registers; tx_byte mirrors busy/err one cycle late.
    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            addr_hi  <= '0;
            fill_val <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err      <= 1'b0;
            tx_byte  <= '0;
        end else begin
            ptr      <= ptr_d;
            addr_hi  <= addr_hi_d;
            fill_val <= fill_val_d;
            wr_en    <= wr_en_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
            err      <= err_d;
            tx_byte  <= {busy, err, 6'b0};
        end
    end

endmodule

// File: tb/tb_spi_fb_writer.sv
// Self-checking bench for spi_fb_writer: transaction-level reference model
// (expected writes and error events stamped with their due cycle) compared
// every cycle, plus literal expectations for the directed cases.
module tb_spi_fb_writer;
    import fb_pkg::*;

    localparam int FB = 38400;

    logic        main_clk = 1'b0;
    logic        rst;
    logic        cs_n;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic [7:0]  tx_byte;
    logic        busy;
    logic        err;

    spi_fb_writer #(.FB_BYTES(FB), .ADDR_W(16)) dut (
        .main_clk (main_clk),
        .rst      (rst),
        .cs_n     (cs_n),
        .rx_dv    (rx_dv),
        .rx_byte  (rx_byte),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .tx_byte  (tx_byte),
        .busy     (busy),
        .err      (err)
    );

    always #5 main_clk = ~main_clk;

    int cyc = 0;
    always @(posedge main_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct { int cyc; logic [15:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int cyc; logic val; } err_ev_t;

    wr_t         wq[$];
    err_ev_t     eq[$];
    int          fill_start = -1;
    logic [7:0]  fill_val   = 8'h00;
    logic        exp_err    = 1'b0;
    logic        prev_err   = 1'b0;
    logic        prev_busy  = 1'b0;
    int          wr_seen    = 0;
    logic [15:0] last_wr_addr = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge main_clk) begin : cmp
        logic        exp_busy;
        logic        exp_wr;
        logic [15:0] ea;
        logic [7:0]  ed;
        if (rst) begin
            check("rst_wr_en", wr_en, 0);
            check("rst_busy", busy, 0);
            check("rst_err", err, 0);
            check("rst_tx_byte", tx_byte, 0);
            exp_err   = 1'b0;
            prev_err  = 1'b0;
            prev_busy = 1'b0;
        end else begin
            while (eq.size() > 0 && eq[0].cyc <= cyc) begin
                exp_err = eq[0].val;
                void'(eq.pop_front());
            end
            exp_busy = (fill_start >= 0) && (cyc >= fill_start) && (cyc < fill_start + FB);
            exp_wr = 1'b0;
            ea     = 16'h0;
            ed     = 8'h0;
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                check("missed_write_slot", cyc, wq[0].cyc);
                void'(wq.pop_front());
            end
            if (exp_busy) begin
                exp_wr = 1'b1;
                ea     = 16'(cyc - fill_start);
                ed     = fill_val;
            end else if (wq.size() > 0 && wq[0].cyc == cyc) begin
                exp_wr = 1'b1;
                ea     = wq[0].addr;
                ed     = wq[0].data;
                void'(wq.pop_front());
            end
            check("wr_en", wr_en, exp_wr);
            if (exp_wr && wr_en) begin
                check("wr_addr", wr_addr, ea);
                check("wr_data", wr_data, ed);
            end
            check("busy", busy, exp_busy);
            check("err", err, exp_err);
            check("tx_byte", tx_byte, {prev_busy, prev_err, 6'b0});
            prev_busy = exp_busy;
            prev_err  = exp_err;
        end
        if (wr_en) begin
            wr_seen++;
            last_wr_addr = wr_addr;
        end
    end

    // ---------------- stimulus helpers (all called at a falling edge) ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge main_clk);
    endtask

    function automatic int rgap();
        return int'($urandom_range(0, 2));
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(negedge main_clk);
        rx_dv   = 1'b0;
        tick(gap);
    endtask

    task automatic send_data(input logic [7:0] b, input logic [15:0] addr, input int gap);
        wq.push_back(wr_t'{cyc + 1, addr, b});
        send(b, gap);
    endtask

    task automatic send_err(input logic [7:0] b, input logic val, input int gap);
        eq.push_back(err_ev_t'{cyc + 1, val});
        send(b, gap);
    endtask

    task automatic begin_txn();
        cs_n = 1'b0;
        tick(3);
    endtask

    task automatic end_txn();
        cs_n = 1'b1;
        tick(4);
    endtask

    task automatic do_write(input logic [15:0] start, input int n);
        logic [15:0] a;
        bit          legal;
        legal = int'(start) < FB;
        begin_txn();
        send(OP_WRITE, rgap());
        send(start[15:8], rgap());
        if (legal) send(start[7:0], rgap());
        else       send_err(start[7:0], 1'b1, rgap());
        a = start;
        for (int i = 0; i < n; i++) begin
            if (legal) begin
                send_data(8'($urandom), a, rgap());
                a = (a == 16'(FB - 1)) ? 16'd0 : a + 16'd1;
            end else begin
                send(8'($urandom), rgap());
            end
        end
        end_txn();
    endtask

    task automatic do_status();
        begin_txn();
        send_err(OP_STATUS, 1'b0, rgap());
        end_txn();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int wr0;
        int kind;
        rst     = 1'b1;
        cs_n    = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        tick(3);
        #1;
        check("reset_wr_en", wr_en, 0);
        check("reset_wr_addr", wr_addr, 16'h0000);
        check("reset_wr_data", wr_data, 8'h00);
        check("reset_tx_byte", tx_byte, 8'h00);
        @(negedge main_clk);
        rst = 1'b0;
        tick(2);

        // Basic WRITE: one-cycle writes one cycle after each byte.
        begin_txn();
        send(OP_WRITE, 0);
        send(8'h00, 0);
        send(8'h10, 1);
        send_data(8'hAA, 16'h0010, 0);
        check("write0_en", wr_en, 1);
        check("write0_addr", wr_addr, 16'h0010);
        check("write0_data", wr_data, 8'hAA);
        send_data(8'h55, 16'h0011, 0);
        check("write1_addr", wr_addr, 16'h0011);
        check("write1_data", wr_data, 8'h55);
        tick(1);
        check("write_single_cycle", wr_en, 0);
        check("write_no_err", err, 0);
        end_txn();

        // Pointer wrap at the last framebuffer byte.
        begin_txn();
        send(OP_WRITE, 0);
        send(8'h95, 0);
        send(8'hFF, 0);
        send_data(8'h11, 16'h95FF, 0);
        check("wrap_last_addr", wr_addr, 16'h95FF);
        send_data(8'h22, 16'h0000, 0);
        check("wrap_first_addr", wr_addr, 16'h0000);
        check("wrap_data", wr_data, 8'h22);
        end_txn();

        // Out-of-range header address, then STATUS clears the error.
        begin_txn();
        send(OP_WRITE, 0);
        send(8'h96, 0);
        send_err(8'h00, 1'b1, 0);
        check("bad_addr_err", err, 1);
        tick(1);
        check("bad_addr_tx", tx_byte, 8'h40);
        send(8'h99, 2);
        end_txn();
        begin_txn();
        send_err(OP_STATUS, 1'b0, 0);
        check("status_clr_err", err, 0);
        tick(1);
        check("status_clr_tx", tx_byte, 8'h00);
        end_txn();

        // Unknown opcode: error, following bytes discarded.
        begin_txn();
        send_err(8'h7E, 1'b1, 0);
        check("unknown_op_err", err, 1);
        send(OP_WRITE, 0);
        send(8'h00, 0);
        send(8'h10, 0);
        send(8'hAB, 1);
        end_txn();
        do_status();

        // Byte arriving with cs_s already high is written; next txn from CMD.
        begin_txn();
        send(OP_WRITE, 0);
        send(8'h00, 0);
        send(8'h20, 0);
        send_data(8'h5A, 16'h0020, 0);
        cs_n = 1'b1;
        tick(2);
        send_data(8'h5B, 16'h0021, 0);
        check("cs_edge_write_addr", wr_addr, 16'h0021);
        cs_n = 1'b0;
        tick(3);
        send(OP_WRITE, 0);
        send(8'h00, 0);
        send(8'h40, 0);
        send_data(8'h77, 16'h0040, 0);
        check("after_cs_addr", wr_addr, 16'h0040);
        check("after_cs_data", wr_data, 8'h77);
        end_txn();

        // Full FILL with a stray byte and CS raised mid-fill.
        wr0 = wr_seen;
        begin_txn();
        send(OP_FILL, 0);
        fill_val   = 8'hFF;
        fill_start = cyc + 1;
        send(8'hFF, 0);
        check("fill_busy_start", busy, 1);
        check("fill_first_addr", wr_addr, 16'h0000);
        tick(100);
        eq.push_back(err_ev_t'{cyc + 1, 1'b1});
        send(8'h33, 0);
        check("fill_stray_err", err, 1);
        tick(1);
        check("fill_tx", tx_byte, 8'hC0);
        cs_n = 1'b1;
        while (cyc < fill_start + FB + 3) tick(1);
        check("fill_busy_end", busy, 0);
        check("fill_count", wr_seen - wr0, FB);
        check("fill_last_addr", last_wr_addr, 16'd38399);
        check("fill_end_tx", tx_byte, 8'h40);
        fill_start = -1;
        tick(2);
        do_status();

        // Reset in the middle of a fill.
        begin_txn();
        send(OP_FILL, 0);
        fill_val   = 8'hA5;
        fill_start = cyc + 1;
        send(8'hA5, 0);
        tick(50);
        #2;
        rst = 1'b1;
        fill_start = -1;
        wq.delete();
        eq.delete();
        #1;
        check("rst_mid_fill_wr_en", wr_en, 0);
        check("rst_mid_fill_busy", busy, 0);
        check("rst_mid_fill_addr", wr_addr, 16'h0000);
        @(negedge main_clk);
        tick(1);
        rst  = 1'b0;
        cs_n = 1'b1;
        tick(3);
        begin_txn();
        send(OP_WRITE, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        send_data(8'hC3, 16'h1234, 0);
        check("post_rst_addr", wr_addr, 16'h1234);
        check("post_rst_data", wr_data, 8'hC3);
        end_txn();

        // Randomized transaction mix.
        for (int k = 0; k < 40; k++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 5) begin
                do_write(16'($urandom_range(0, FB - 1)), int'($urandom_range(1, 6)));
            end else if (kind == 6) begin
                do_status();
            end else if (kind == 7) begin
                begin_txn();
                send_err(8'($urandom_range(4, 255)), 1'b1, rgap());
                send(8'($urandom), rgap());
                end_txn();
            end else if (kind == 8) begin
                do_write(16'($urandom_range(FB, 65535)), 2);
            end else begin
                do_write(16'(FB - int'($urandom_range(1, 3))), 4);
            end
        end

        tick(5);
        check("queues_drained", wq.size() + eq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
